// File: rtl/video_pattern_gen.sv
// video_pattern_gen: raster timing generator (active/front porch/sync/back porch)
// with four selectable test patterns and a fixed one-clock output latency.
// Optional feature macro: VPG_FRAME_CNT_EN adds o_frame_cnt and scrolls the bars.
module video_pattern_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_en,
  input  logic [1:0] i_pat_sel,
  output logic       o_vsync,
  output logic       o_hsync,
  output logic       o_de,
  output logic [9:0] o_r_data,
  output logic [9:0] o_g_data,
  output logic [9:0] o_b_data
`ifdef VPG_FRAME_CNT_EN
  ,
  output logic [7:0] o_frame_cnt
`endif
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Counters are at least 10 bits wide (horizontal) / 5 bits (vertical) so the
  // ramp and checkerboard bit taps always exist.
  localparam int unsigned HW       = ($clog2(H_TOTAL) > 10) ? $clog2(H_TOTAL) : 10;
  localparam int unsigned VW       = ($clog2(V_TOTAL) > 5) ? $clog2(V_TOTAL) : 5;
  localparam int unsigned BW       = HW + 3;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [1:0]    pat_q, pat_d;
  logic          de_q, de_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic [9:0]    r_q, r_d;
  logic [9:0]    g_q, g_d;
  logic [9:0]    b_q, b_d;

  logic          h_last;
  logic          v_last;
  logic          frame_start;
  logic          de_term;
  logic          hs_term;
  logic          vs_term;
  logic [2:0]    bar_idx;
  logic [2:0]    bar_sel;
  logic          chk_bit;
  logic [9:0]    pix_r;
  logic [9:0]    pix_g;
  logic [9:0]    pix_b;

`ifdef VPG_FRAME_CNT_EN
  logic [7:0]    frame_cnt_q, frame_cnt_d;
`endif

  // Raster position decode from the current counter state
  always_comb begin
    h_last      = (h_cnt_q == HW'(H_TOTAL - 1));
    v_last      = (v_cnt_q == VW'(V_TOTAL - 1));
    frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);
    de_term     = (h_cnt_q < HW'(H_ACTIVE)) && (v_cnt_q < VW'(V_ACTIVE));
    hs_term     = (h_cnt_q >= HW'(HS_START)) && (h_cnt_q < HW'(HS_END));
    vs_term     = (v_cnt_q >= VW'(VS_START)) && (v_cnt_q < VW'(VS_END));
  end

  // Counter advance; disabling parks both counters at the frame origin
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!i_en) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_last) begin
      h_cnt_d = '0;
      v_cnt_d = v_last ? '0 : v_cnt_q + VW'(1);
    end else begin
      h_cnt_d = h_cnt_q + HW'(1);
    end
  end

  // Pattern is latched only at the frame origin; the origin pixel already uses the new value
  always_comb begin
    pat_d = frame_start ? i_pat_sel : pat_q;
  end

  // Colour-bar index: number of bar boundaries at or left of the current pixel
  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < 8; k++) begin
      if ({h_cnt_q, 3'b000} >= BW'(k * H_ACTIVE)) begin
        bar_idx = bar_idx + 3'd1;
      end
    end
  end

  // Bar scrolling by frame count when the frame counter is present
  always_comb begin
`ifdef VPG_FRAME_CNT_EN
    bar_sel = bar_idx + frame_cnt_q[2:0];
`else
    bar_sel = bar_idx;
`endif
  end

  // Pattern pixel generation
  always_comb begin
    chk_bit = h_cnt_q[4] ^ v_cnt_q[4];
    pix_r   = '0;
    pix_g   = '0;
    pix_b   = '0;
    unique case (pat_d)
      2'd0: begin
        pix_r = {10{~bar_sel[1]}};
        pix_g = {10{~bar_sel[2]}};
        pix_b = {10{~bar_sel[0]}};
      end
      2'd1: begin
        pix_r = h_cnt_q[9:0];
        pix_g = h_cnt_q[9:0];
        pix_b = h_cnt_q[9:0];
      end
      2'd2: begin
        pix_r = {10{chk_bit}};
        pix_g = {10{chk_bit}};
        pix_b = {10{chk_bit}};
      end
      default: begin
        pix_r = 10'h200;
        pix_g = 10'h200;
        pix_b = 10'h200;
      end
    endcase
  end

  // Output next-state: blanked when disabled, RGB forced to 0 outside active video
  always_comb begin
    de_d = 1'b0;
    hs_d = 1'b0;
    vs_d = 1'b0;
    r_d  = '0;
    g_d  = '0;
    b_d  = '0;
    if (i_en) begin
      de_d = de_term;
      hs_d = hs_term;
      vs_d = vs_term;
      if (de_term) begin
        r_d = pix_r;
        g_d = pix_g;
        b_d = pix_b;
      end
    end
  end

`ifdef VPG_FRAME_CNT_EN
  // Frame counter steps on the vertical wrap and rolls over naturally at 255
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (i_en && h_last && v_last) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  // Frame counter register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign o_frame_cnt = frame_cnt_q;
`endif

  // Counter, pattern and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      pat_q   <= '0;
      de_q    <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      pat_q   <= pat_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
    end
  end

  assign o_de     = de_q;
  assign o_hsync  = hs_q;
  assign o_vsync  = vs_q;
  assign o_r_data = r_q;
  assign o_g_data = g_q;
  assign o_b_data = b_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// tb_video_pattern_gen: scoreboard bench for video_pattern_gen on a reduced raster
// (80x27 clocks/lines) so several whole frames fit in a short run.
module tb_video_pattern_gen;

  localparam int HA = 64;
  localparam int HF = 4;
  localparam int HS = 8;
  localparam int HB = 4;
  localparam int VA = 20;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic       vs;
    logic       hs;
    logic       de;
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
    logic [7:0] fc;
  } out_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic       en;
  logic [1:0] pat;
  logic       o_vsync, o_hsync, o_de;
  logic [9:0] o_r_data, o_g_data, o_b_data;
`ifdef VPG_FRAME_CNT_EN
  logic [7:0] o_frame_cnt;
`endif

  out_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   m_h = 0, m_v = 0, m_pat = 0, m_fc = 0;

  always #5 clk = ~clk;

  video_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .i_en       (en),
    .i_pat_sel  (pat),
    .o_vsync    (o_vsync),
    .o_hsync    (o_hsync),
    .o_de       (o_de),
    .o_r_data   (o_r_data),
    .o_g_data   (o_g_data),
    .o_b_data   (o_b_data)
`ifdef VPG_FRAME_CNT_EN
    ,
    .o_frame_cnt(o_frame_cnt)
`endif
  );

  function automatic out_t obs();
    out_t o;
    o.vs = o_vsync;
    o.hs = o_hsync;
    o.de = o_de;
    o.r  = o_r_data;
    o.g  = o_g_data;
    o.b  = o_b_data;
`ifdef VPG_FRAME_CNT_EN
    o.fc = o_frame_cnt;
`else
    o.fc = 8'h00;
`endif
    return o;
  endfunction

  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Reference model: expected outputs for the coming edge, then advance model state
  task automatic model_next(output out_t e);
    logic [7:0] rt, gt, bt;
    int p, b;
    rt = 8'h33;
    gt = 8'h0F;
    bt = 8'h55;
    e = '0;
    if (!rstn) begin
      m_h = 0; m_v = 0; m_pat = 0; m_fc = 0;
    end else begin
      p = (m_h == 0 && m_v == 0) ? int'(pat) : m_pat;
      if (en) begin
        e.de = (m_h < HA) && (m_v < VA);
        e.hs = (m_h >= HA + HF) && (m_h < HA + HF + HS);
        e.vs = (m_v >= VA + VF) && (m_v < VA + VF + VS);
        if (e.de) begin
          case (p)
            0: begin
`ifdef VPG_FRAME_CNT_EN
              b = ((m_h * 8) / HA + m_fc) % 8;
`else
              b = (m_h * 8) / HA;
`endif
              e.r = rt[b] ? 10'h3FF : 10'h000;
              e.g = gt[b] ? 10'h3FF : 10'h000;
              e.b = bt[b] ? 10'h3FF : 10'h000;
            end
            1: begin
              e.r = 10'(m_h);
              e.g = 10'(m_h);
              e.b = 10'(m_h);
            end
            2: begin
              e.r = ((((m_h >> 4) ^ (m_v >> 4)) & 1) != 0) ? 10'h3FF : 10'h000;
              e.g = e.r;
              e.b = e.r;
            end
            default: begin
              e.r = 10'h200;
              e.g = 10'h200;
              e.b = 10'h200;
            end
          endcase
        end
      end
`ifdef VPG_FRAME_CNT_EN
      e.fc = 8'(m_fc);
`endif
      if (m_h == 0 && m_v == 0) m_pat = int'(pat);
      if (en) begin
        if (m_h == HT - 1 && m_v == VT - 1) m_fc = (m_fc + 1) % 256;
        if (m_h == HT - 1) begin
          m_h = 0;
          m_v = (m_v == VT - 1) ? 0 : m_v + 1;
        end else begin
          m_h = m_h + 1;
        end
      end else begin
        m_h = 0;
        m_v = 0;
      end
    end
  endtask

  // One clock: push the expectation, take the edge, pop and compare
  task automatic step();
    out_t e, o;
    model_next(e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    o = obs();
    e = sb_q.pop_front();
    check($sformatf("pix c%0d", cyc), 64'(o), 64'(e));
  endtask

  task automatic step_until(input int h, input int v);
    int n;
    n = 0;
    while (!(m_h == h && m_v == v)) begin
      step();
      n++;
      if (n > 3 * FRAME) begin
        checks++;
        errors++;
        $error("FAIL timeout waiting h=%0d v=%0d observed_steps=%0d required_max=%0d", h, v, n, 3 * FRAME);
        break;
      end
    end
  endtask

  int   st_de, st_vs, st_hs, first_hs, vs_r1, vs_r2;
  logic prev_vs;
  out_t px0, px8, px63;

  initial begin
    rstn = 1'b0;
    en   = 1'b0;
    pat  = 2'd0;
    st_de = 0; st_vs = 0; st_hs = 0; first_hs = 0; vs_r1 = 0; vs_r2 = 0;
    prev_vs = 1'b0;
    #12;
    check("reset_state", 64'(obs()), 64'(0));

    // Reset release with enable already high starts the raster at the origin
    en   = 1'b1;
    rstn = 1'b1;
    for (int k = 1; k <= 2 * FRAME + 10; k++) begin
      step();
      if (k == 1) check("first_de", 64'(o_de), 64'(1));
      if (k <= FRAME) begin
        if (o_de) st_de++;
        if (o_vsync) st_vs++;
      end
      if (k <= HT && o_hsync) begin
        st_hs++;
        if (first_hs == 0) first_hs = k;
      end
      if (o_vsync && !prev_vs) begin
        if (vs_r1 == 0) vs_r1 = k;
        else if (vs_r2 == 0) vs_r2 = k;
      end
      prev_vs = o_vsync;
      if (k == 1)  px0  = obs();
      if (k == 9)  px8  = obs();
      if (k == 64) px63 = obs();
    end
    check("de_per_frame", 64'(st_de), 64'(HA * VA));
    check("vsync_clocks", 64'(st_vs), 64'(VS * HT));
    check("hsync_rise", 64'(first_hs), 64'(HA + HF + 1));
    check("hsync_width", 64'(st_hs), 64'(HS));
    check("vsync_first_rise", 64'(vs_r1), 64'((VA + VF) * HT + 1));
    check("frame_period", 64'(vs_r2 - vs_r1), 64'(FRAME));
    check("bar_px0", 64'({px0.r, px0.g, px0.b}), 64'({10'h3FF, 10'h3FF, 10'h3FF}));
    check("bar_px8", 64'({px8.r, px8.g, px8.b}), 64'({10'h3FF, 10'h3FF, 10'h000}));
    check("bar_px63", 64'({px63.r, px63.g, px63.b}), 64'(0));

    // Mid-frame pattern change only takes effect at the next frame origin
    step_until(10, 3);
    pat = 2'd1;
    step_until(0, 0);
    for (int k = 0; k < 6; k++) step();
    check("ramp_px5", 64'({o_r_data, o_g_data, o_b_data}), 64'({10'h005, 10'h005, 10'h005}));

    // Disable mid-frame, then re-enable into the checkerboard
    step_until(20, 12);
    en = 1'b0;
    step();
    check("disable_zero", 64'(obs()), 64'(0));
    for (int k = 0; k < 5; k++) step();
    pat = 2'd2;
    en  = 1'b1;
    step();
    check("reenable_de", 64'(o_de), 64'(1));

    // Asynchronous reset mid-line clears outputs without a clock edge
    step_until(30, 18);
    rstn = 1'b0;
    #1;
    check("async_rst", 64'(obs()), 64'(0));
    m_h = 0; m_v = 0; m_pat = 0; m_fc = 0;
    for (int k = 0; k < 3; k++) step();
    pat  = 2'd3;
    rstn = 1'b1;
    for (int k = 0; k < FRAME + 5; k++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
